// File: rtl/tu_scheduler.sv
// Time-unit scheduler: sequences per-image evaluation of the output neuron block,
// accumulates per-neuron spike totals and picks the winning neuron.
module tu_scheduler #(
    parameter int N       = 8,
    parameter int T_STEPS = 350,
    parameter int TO_CYC  = 4095,
    parameter int CW      = 8,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_img,
    input  logic            valid_op_nub,
    input  logic [N-1:0]    spike_op_nub,
    output logic            start_core_img,
    output logic            start_op_nub,
    output logic            TU_incre,
    output logic [9:0]      tu_cnt,
    output logic            busy,
    output logic            img_done,
    output logic            timeout_err,
    output logic [N*CW-1:0] spike_cnt,
    output logic [IW-1:0]   winner
);

    // state  | meaning
    // IDLE   | waiting for start_img
    // INIT   | clear per-image state, pulse start_core_img
    // FIRE   | launch one time-unit evaluation
    // WAIT   | wait for valid_op_nub under watchdog
    // ADV    | advance time unit or finish
    // DONE   | register winner, pulse img_done
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_FIRE, S_WAIT, S_ADV, S_DONE} state_t;

    localparam logic [9:0]  TU_LAST = 10'(T_STEPS - 1);
    localparam logic [15:0] WD_LAST = 16'(TO_CYC - 1);

    state_t               state_q, state_d;
    logic [9:0]           tu_q, tu_d;
    logic [15:0]          wd_q, wd_d;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]        win_q, win_d, best_idx;
    logic [CW-1:0]        best_val;
    logic                 tmo_q, tmo_d;
    logic                 core_q, fire_q, incr_q, done_q;

    // Strict greater-than keeps the lowest index on ties and yields 0 when all counts are zero.
    always_comb begin
        best_val = cnt_q[0];
        best_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (cnt_q[i] > best_val) begin
                best_val = cnt_q[i];
                best_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tu_d    = tu_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_img) state_d = S_INIT;
            end
            S_INIT: begin
                tu_d    = '0;
                wd_d    = '0;
                cnt_d   = '0;
                tmo_d   = 1'b0;
                state_d = S_FIRE;
            end
            S_FIRE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (valid_op_nub) begin
                    for (int i = 0; i < N; i++) begin
                        if (spike_op_nub[i] && (cnt_q[i] != {CW{1'b1}})) cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                    state_d = S_ADV;
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_ADV: begin
                if (tu_q == TU_LAST) begin
                    state_d = S_DONE;
                end else begin
                    tu_d    = tu_q + 10'd1;
                    state_d = S_FIRE;
                end
            end
            S_DONE: begin
                win_d   = best_idx;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are decoded from the next state so each one is a flop that is high for exactly the state's cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tu_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            tmo_q   <= 1'b0;
            core_q  <= 1'b0;
            fire_q  <= 1'b0;
            incr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tu_q    <= tu_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            tmo_q   <= tmo_d;
            core_q  <= (state_d == S_INIT);
            fire_q  <= (state_d == S_FIRE);
            incr_q  <= (state_d == S_ADV);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign start_core_img = core_q;
    assign start_op_nub   = fire_q;
    assign TU_incre       = incr_q;
    assign img_done       = done_q;
    assign tu_cnt         = tu_q;
    assign busy           = (state_q != S_IDLE);
    assign timeout_err    = tmo_q;
    assign spike_cnt      = cnt_q;
    assign winner         = win_q;

endmodule

// File: tb/tb_tu_scheduler.sv
// Directed bench for tu_scheduler: a short-image instance (T_STEPS=3, TO_CYC=10)
// and a long-image instance (T_STEPS=300) each driven by a simple neuron-block responder.
module tb_tu_scheduler;

    logic        clk, rst;
    logic        start_a, valid_a, start_b, valid_b;
    logic [7:0]  spike_a, spike_b;
    logic        core_a, op_a, incr_a, busy_a, done_a, tmo_a;
    logic        core_b, op_b, incr_b, busy_b, done_b, tmo_b;
    logic [9:0]  tu_a, tu_b;
    logic [63:0] cnt_a, cnt_b;
    logic [2:0]  win_a, win_b;

    logic resp_en_a, force_valid_a, spur_adv_a, pend_a;
    logic resp_en_b, pend_b;

    int errors, checks, cyc;
    int cnt_core_a, cnt_op_a, cnt_incr_a, cnt_done_a, first_op_a, core_cyc_a;
    int cnt_op_b, cnt_incr_b, cnt_done_b;
    int excl;
    logic op_seen_a;
    int s_core, s_op, s_incr, s_done, done_at;

    tu_scheduler #(.N(8), .T_STEPS(3), .TO_CYC(10), .CW(8)) u_a (
        .clk(clk), .rst(rst), .start_img(start_a), .valid_op_nub(valid_a), .spike_op_nub(spike_a),
        .start_core_img(core_a), .start_op_nub(op_a), .TU_incre(incr_a), .tu_cnt(tu_a),
        .busy(busy_a), .img_done(done_a), .timeout_err(tmo_a), .spike_cnt(cnt_a), .winner(win_a)
    );

    tu_scheduler #(.N(8), .T_STEPS(300), .TO_CYC(4095), .CW(8)) u_b (
        .clk(clk), .rst(rst), .start_img(start_b), .valid_op_nub(valid_b), .spike_op_nub(spike_b),
        .start_core_img(core_b), .start_op_nub(op_b), .TU_incre(incr_b), .tu_cnt(tu_b),
        .busy(busy_b), .img_done(done_b), .timeout_err(tmo_b), .spike_cnt(cnt_b), .winner(win_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Responders return valid in the cycle after start_op_nub; extra sources inject spurious valids.
    initial begin
        valid_a = 1'b0; pend_a = 1'b0;
        forever begin
            @(negedge clk);
            valid_a = (resp_en_a & pend_a) | force_valid_a | (spur_adv_a & incr_a);
            pend_a  = op_a;
        end
    end

    initial begin
        valid_b = 1'b0; pend_b = 1'b0;
        forever begin
            @(negedge clk);
            valid_b = resp_en_b & pend_b;
            pend_b  = op_b;
        end
    end

    always @(negedge clk) begin
        if (core_a) begin
            cnt_core_a <= cnt_core_a + 1;
            core_cyc_a <= cyc;
            op_seen_a  <= 1'b0;
        end
        if (op_a) begin
            cnt_op_a <= cnt_op_a + 1;
            if (!op_seen_a) begin
                first_op_a <= cyc;
                op_seen_a  <= 1'b1;
            end
        end
        if (incr_a) cnt_incr_a <= cnt_incr_a + 1;
        if (done_a) cnt_done_a <= cnt_done_a + 1;
        if (op_b)   cnt_op_b   <= cnt_op_b + 1;
        if (incr_b) cnt_incr_b <= cnt_incr_b + 1;
        if (done_b) cnt_done_b <= cnt_done_b + 1;
        if ((int'(core_a) + int'(op_a) + int'(incr_a) + int'(done_a) > 1) ||
            (int'(core_b) + int'(op_b) + int'(incr_b) + int'(done_b) > 1))
            excl <= excl + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snap_a();
        s_core = cnt_core_a; s_op = cnt_op_a; s_incr = cnt_incr_a; s_done = cnt_done_a;
    endtask

    task automatic snap_b();
        s_op = cnt_op_b; s_incr = cnt_incr_b; s_done = cnt_done_b;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Returns on the negedge where img_done is seen, then settles one more cycle into IDLE.
    task automatic wait_done(input bit sel, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (sel ? done_b : done_a) begin
                seen    = 1'b1;
                done_at = cyc;
            end
        end
        check_eq(tag, int'(seen), 1);
        @(negedge clk);
    endtask

    initial begin
        bit found;
        errors = 0; checks = 0; cyc = 0; excl = 0;
        cnt_core_a = 0; cnt_op_a = 0; cnt_incr_a = 0; cnt_done_a = 0;
        first_op_a = 0; core_cyc_a = 0; op_seen_a = 1'b0;
        cnt_op_b = 0; cnt_incr_b = 0; cnt_done_b = 0;
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; spike_a = 8'h00; spike_b = 8'h00;
        resp_en_a = 1'b0; force_valid_a = 1'b0; spur_adv_a = 1'b0; resp_en_b = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy_a | busy_b), 0);
        check_eq("rst_pulses", int'(core_a | op_a | incr_a | done_a | core_b | op_b | incr_b | done_b), 0);
        check_eq("rst_tu_cnt", int'(tu_a | tu_b), 0);
        check_eq("rst_spike_cnt", int'(|{cnt_a, cnt_b}), 0);
        check_eq("rst_winner_tmo", int'(|{win_a, win_b, tmo_a, tmo_b}), 0);
        rst = 1'b1;
        @(negedge clk);

        // Three time units, neurons 0 and 2 spike each step.
        spike_a = 8'h05; resp_en_a = 1'b1;
        snap_a();
        pulse_start(1'b0);
        wait_done(1'b0, 100, "r1_done_seen");
        check_eq("r1_start_op_pulses", cnt_op_a - s_op, 3);
        check_eq("r1_tu_incre_pulses", cnt_incr_a - s_incr, 3);
        check_eq("r1_core_pulses", cnt_core_a - s_core, 1);
        check_eq("r1_cnt0", int'(cnt_a[7:0]), 3);
        check_eq("r1_cnt1", int'(cnt_a[15:8]), 0);
        check_eq("r1_cnt2", int'(cnt_a[23:16]), 3);
        check_eq("r1_winner", int'(win_a), 0);
        check_eq("r1_tu_cnt_held", int'(tu_a), 2);
        // INIT, then three (FIRE, WAIT, ADV) groups: done lands 9 cycles after INIT completes.
        check_eq("r1_done_after_first_fire", done_at - first_op_a, 9);
        check_eq("r1_done_after_init", done_at - core_cyc_a, 10);
        check_eq("r1_busy_idle", int'(busy_a), 0);

        // Tie on neurons 2 and 6, spurious valid in every ADV, restart attempt while busy.
        spike_a = 8'h44; spur_adv_a = 1'b1;
        snap_a();
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        pulse_start(1'b0);
        wait_done(1'b0, 100, "r2_done_seen");
        spur_adv_a = 1'b0;
        check_eq("r2_core_pulses", cnt_core_a - s_core, 1);
        check_eq("r2_start_op_pulses", cnt_op_a - s_op, 3);
        check_eq("r2_done_pulses", cnt_done_a - s_done, 1);
        check_eq("r2_done_after_first_fire", done_at - first_op_a, 9);
        check_eq("r2_cnt2", int'(cnt_a[23:16]), 3);
        check_eq("r2_cnt6", int'(cnt_a[55:48]), 3);
        check_eq("r2_cnt0", int'(cnt_a[7:0]), 0);
        check_eq("r2_winner_tie", int'(win_a), 2);

        force_valid_a = 1'b1;
        repeat (4) @(negedge clk);
        force_valid_a = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_valid_cnt2", int'(cnt_a[23:16]), 3);
        check_eq("idle_valid_winner", int'(win_a), 2);
        check_eq("idle_valid_busy", int'(busy_a), 0);
        check_eq("idle_valid_no_fire", cnt_op_a - s_op, 3);

        // Watchdog: no valid returned.
        resp_en_a = 1'b0;
        snap_a();
        pulse_start(1'b0);
        wait_done(1'b0, 100, "to_done_seen");
        check_eq("to_timeout_err", int'(tmo_a), 1);
        check_eq("to_no_tu_incre", cnt_incr_a - s_incr, 0);
        check_eq("to_start_op_pulses", cnt_op_a - s_op, 1);
        check_eq("to_done_after_fire", done_at - first_op_a, 11);
        check_eq("to_cnt_cleared", int'(cnt_a[23:16]), 0);
        check_eq("to_winner_all_zero", int'(win_a), 0);

        resp_en_a = 1'b1; spike_a = 8'h02;
        pulse_start(1'b0);
        repeat (2) @(negedge clk);
        check_eq("to_cleared_by_start", int'(tmo_a), 0);
        wait_done(1'b0, 100, "r4_done_seen");
        check_eq("r4_cnt1", int'(cnt_a[15:8]), 3);
        check_eq("r4_winner", int'(win_a), 1);
        check_eq("r4_timeout_err", int'(tmo_a), 0);

        // Asynchronous reset in WAIT at tu_cnt=5 on the long instance.
        spike_b = 8'h80; resp_en_b = 1'b1;
        snap_b();
        pulse_start(1'b1);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (op_b && tu_b == 10'd5) found = 1'b1;
        end
        check_eq("rst_reach_tu5", int'(found), 1);
        @(negedge clk);
        check_eq("pre_rst_cnt7", int'(cnt_b[63:56]), 5);
        #1 rst = 1'b0;
        #1;
        check_eq("async_rst_busy", int'(busy_b), 0);
        check_eq("async_rst_tu_cnt", int'(tu_b), 0);
        check_eq("async_rst_spike_cnt", int'(|cnt_b), 0);
        check_eq("async_rst_pulses", int'(core_b | op_b | incr_b | done_b), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("async_rst_no_done", cnt_done_b - s_done, 0);
        check_eq("async_rst_stays_idle", int'(busy_b), 0);

        // Full 300-step image; neuron 7 saturates.
        snap_b();
        pulse_start(1'b1);
        wait_done(1'b1, 1200, "sat_done_seen");
        check_eq("sat_cnt7", int'(cnt_b[63:56]), 255);
        check_eq("sat_cnt0", int'(cnt_b[7:0]), 0);
        check_eq("sat_winner", int'(win_b), 7);
        check_eq("sat_tu_cnt_held", int'(tu_b), 299);
        check_eq("sat_start_op_pulses", cnt_op_b - s_op, 300);
        check_eq("sat_tu_incre_pulses", cnt_incr_b - s_incr, 300);

        check_eq("pulse_exclusive", excl, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete, got %0d checks", checks);
        $fatal(1);
    end

endmodule
